// File: rtl/complex_divide_if.sv
// Handshake bundle for complex_divide: numerator and denominator inputs plus
// the quotient output. The design connects to the slave modport.
interface complex_divide_if #(
  parameter int G_DIN_DWIDTH  = 16,
  parameter int G_DOUT_DWIDTH = 16
);
  logic signed [G_DIN_DWIDTH-1:0]  num_re;
  logic signed [G_DIN_DWIDTH-1:0]  num_im;
  logic                            num_valid;
  logic                            num_ready;
  logic signed [G_DIN_DWIDTH-1:0]  den_re;
  logic signed [G_DIN_DWIDTH-1:0]  den_im;
  logic                            den_valid;
  logic                            den_ready;
  logic signed [G_DOUT_DWIDTH-1:0] dout_re;
  logic signed [G_DOUT_DWIDTH-1:0] dout_im;
  logic                            dout_div_by_zero;
  logic                            dout_valid;
  logic                            dout_ready;

  modport master (
    output num_re, num_im, num_valid, den_re, den_im, den_valid, dout_ready,
    input  num_ready, den_ready, dout_re, dout_im, dout_div_by_zero, dout_valid
  );

  modport slave (
    input  num_re, num_im, num_valid, den_re, den_im, den_valid, dout_ready,
    output num_ready, den_ready, dout_re, dout_im, dout_div_by_zero, dout_valid
  );
endinterface

// File: rtl/complex_divide.sv
// Sequential complex divider a/b: products, sums, then a pair of restoring
// dividers sharing one iteration counter, followed by saturation to the output width.
module complex_divide #(
  parameter int G_DIN_DWIDTH  = 16,
  parameter int G_FRAC_BITS   = 14,
  parameter int G_DOUT_DWIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  complex_divide_if.slave bus
);
  localparam int PW = 2*G_DIN_DWIDTH + 1;
  localparam int D  = PW + G_FRAC_BITS;
  localparam int CW = $clog2(D + 1);
  localparam logic [D-1:0]  LIM_POS   = {{(D-G_DOUT_DWIDTH+1){1'b0}}, {(G_DOUT_DWIDTH-1){1'b1}}};
  localparam logic [D-1:0]  LIM_NEG   = LIM_POS + D'(1);
  localparam logic [CW-1:0] ITER_LAST = CW'(D - 1);

  typedef enum logic [2:0] {
    SM_INIT, SM_GET_INPUT, SM_MULTIPLY, SM_ADD, SM_DIVIDE, SM_SATURATE, SM_SEND_OUTPUT
  } state_t;

  state_t r_state, w_next_state;

  logic w_rst, w_take_num, w_take_den, w_out_done;
  logic r_num_ready, r_den_ready;
  logic signed [G_DIN_DWIDTH-1:0] r_ar, r_ai, r_br, r_bi;
  logic signed [PW-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ir, r_p_ri;
  logic signed [PW-1:0] w_pr, w_pi;
  logic [PW-1:0] w_pr_abs, w_pi_abs, w_mag, r_mag;
  logic r_neg_re, r_neg_im, r_dbz;
  logic [D-1:0] r_quo_re, r_quo_im;
  logic [PW-1:0] r_rem_re, r_rem_im, w_rem_re, w_rem_im, w_sub_re, w_sub_im;
  logic [PW:0] w_sh_re, w_sh_im;
  logic w_bit_re, w_bit_im;
  logic [CW-1:0] r_iter;
  logic signed [G_DOUT_DWIDTH-1:0] r_dout_re, r_dout_im, w_sat_re, w_sat_im;
  logic r_dout_valid, r_dout_dbz;

  // Enable low behaves exactly like reset.
  assign w_rst = reset | ~enable;

  assign w_ar = {{(PW-G_DIN_DWIDTH){r_ar[G_DIN_DWIDTH-1]}}, r_ar};
  assign w_ai = {{(PW-G_DIN_DWIDTH){r_ai[G_DIN_DWIDTH-1]}}, r_ai};
  assign w_br = {{(PW-G_DIN_DWIDTH){r_br[G_DIN_DWIDTH-1]}}, r_br};
  assign w_bi = {{(PW-G_DIN_DWIDTH){r_bi[G_DIN_DWIDTH-1]}}, r_bi};

  assign w_pr     = r_p_rr + r_p_ii;
  assign w_pi     = r_p_ir - r_p_ri;
  assign w_pr_abs = w_pr[PW-1] ? -w_pr : w_pr;
  assign w_pi_abs = w_pi[PW-1] ? -w_pi : w_pi;
  assign w_mag    = w_br * w_br + w_bi * w_bi;

  // Remainder stays below mag, so the shifted remainder fits in PW+1 bits
  // and the difference, when taken, fits back in PW bits.
  assign w_sh_re  = {r_rem_re, r_quo_re[D-1]};
  assign w_sh_im  = {r_rem_im, r_quo_im[D-1]};
  assign w_sub_re = w_sh_re[PW-1:0] - r_mag;
  assign w_sub_im = w_sh_im[PW-1:0] - r_mag;
  assign w_bit_re = (w_sh_re >= {1'b0, r_mag});
  assign w_bit_im = (w_sh_im >= {1'b0, r_mag});
  assign w_rem_re = w_bit_re ? w_sub_re : w_sh_re[PW-1:0];
  assign w_rem_im = w_bit_im ? w_sub_im : w_sh_im[PW-1:0];

  function automatic logic signed [G_DOUT_DWIDTH-1:0] saturate(input logic [D-1:0] q,
                                                             input logic neg);
    if (!neg)
      return (q > LIM_POS) ? LIM_POS[G_DOUT_DWIDTH-1:0] : q[G_DOUT_DWIDTH-1:0];
    else
      return (q > LIM_NEG) ? LIM_NEG[G_DOUT_DWIDTH-1:0] : -q[G_DOUT_DWIDTH-1:0];
  endfunction

  assign w_sat_re = saturate(r_quo_re, r_neg_re);
  assign w_sat_im = saturate(r_quo_im, r_neg_im);

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= SM_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SM_INIT:        w_next_state = SM_GET_INPUT;
      SM_GET_INPUT:   if (!r_num_ready && !r_den_ready) w_next_state = SM_MULTIPLY;
      SM_MULTIPLY:    w_next_state = SM_ADD;
      SM_ADD:         w_next_state = SM_DIVIDE;
      SM_DIVIDE:      if (r_mag == '0 || r_iter == ITER_LAST) w_next_state = SM_SATURATE;
      SM_SATURATE:    w_next_state = SM_SEND_OUTPUT;
      SM_SEND_OUTPUT: if (w_out_done) w_next_state = SM_GET_INPUT;
      default:        w_next_state = SM_INIT;
    endcase
  end

  always_comb begin
    w_take_num = 1'b0;
    w_take_den = 1'b0;
    w_out_done = 1'b0;
    if (r_state == SM_INIT || r_state == SM_GET_INPUT) begin
      w_take_num = bus.num_valid && r_num_ready;
      w_take_den = bus.den_valid && r_den_ready;
    end
    if (r_state == SM_SEND_OUTPUT)
      w_out_done = r_dout_valid && bus.dout_ready;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_num_ready  <= 1'b1;
      r_den_ready  <= 1'b1;
      r_dout_valid <= 1'b0;
      r_dout_dbz   <= 1'b0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_iter       <= '0;
    end else begin
      if (r_state == SM_INIT || w_out_done) begin
        r_num_ready <= 1'b1;
        r_den_ready <= 1'b1;
      end
      if (w_out_done) r_dout_valid <= 1'b0;
      if (w_take_num) begin
        r_ar        <= bus.num_re;
        r_ai        <= bus.num_im;
        r_num_ready <= 1'b0;
      end
      if (w_take_den) begin
        r_br        <= bus.den_re;
        r_bi        <= bus.den_im;
        r_den_ready <= 1'b0;
      end
      case (r_state)
        SM_MULTIPLY: begin
          r_p_rr <= w_ar * w_br;
          r_p_ii <= w_ai * w_bi;
          r_p_ir <= w_ai * w_br;
          r_p_ri <= w_ar * w_bi;
        end
        SM_ADD: begin
          r_mag    <= w_mag;
          r_neg_re <= w_pr[PW-1];
          r_neg_im <= w_pi[PW-1];
          r_quo_re <= {w_pr_abs, {G_FRAC_BITS{1'b0}}};
          r_quo_im <= {w_pi_abs, {G_FRAC_BITS{1'b0}}};
          r_rem_re <= '0;
          r_rem_im <= '0;
          r_iter   <= '0;
          r_dbz    <= 1'b0;
        end
        SM_DIVIDE: begin
          if (r_mag == '0) begin
            r_quo_re <= '0;
            r_quo_im <= '0;
            r_dbz    <= 1'b1;
          end else begin
            r_rem_re <= w_rem_re;
            r_rem_im <= w_rem_im;
            r_quo_re <= {r_quo_re[D-2:0], w_bit_re};
            r_quo_im <= {r_quo_im[D-2:0], w_bit_im};
            r_iter   <= r_iter + 1'b1;
          end
        end
        SM_SATURATE: begin
          r_dout_re    <= w_sat_re;
          r_dout_im    <= w_sat_im;
          r_dout_dbz   <= r_dbz;
          r_dout_valid <= 1'b1;
          r_iter       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.num_ready        = r_num_ready;
  assign bus.den_ready        = r_den_ready;
  assign bus.dout_re          = r_dout_re;
  assign bus.dout_im          = r_dout_im;
  assign bus.dout_div_by_zero = r_dout_dbz;
  assign bus.dout_valid       = r_dout_valid;
endmodule

// File: tb/tb_complex_divide.sv
// Bench for complex_divide: a vector table plus hand-written order, divide-by-zero
// and mid-division reset sequences, with expected quotients kept in a scoreboard queue.
module tb_complex_divide;
  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  complex_divide_if #(.G_DIN_DWIDTH(16), .G_DOUT_DWIDTH(16)) bus ();

  complex_divide #(
    .G_DIN_DWIDTH(16),
    .G_FRAC_BITS(14),
    .G_DOUT_DWIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus)
  );

  typedef struct {
    logic signed [15:0] nr, ni, dr, di;
    int                 gap;
    int                 hold;
    logic signed [15:0] er, ei;
    logic               edbz;
  } vec_t;

  typedef struct {
    logic signed [15:0] er, ei;
    logic               edbz;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   captureCycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int nr, input int ni, input int dr, input int di,
                              input int gap, input int hold,
                              input int er, input int ei, input int edbz);
    vec_t v;
    v.nr = 16'(nr); v.ni = 16'(ni); v.dr = 16'(dr); v.di = 16'(di);
    v.gap = gap; v.hold = hold;
    v.er = 16'(er); v.ei = 16'(ei); v.edbz = edbz[0];
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the second capture.
  task automatic applyStimulus(input vec_t v, input bit doPush);
    exp_t e;
    if (doPush) begin
      e.er = v.er; e.ei = v.ei; e.edbz = v.edbz;
      sb.push_back(e);
    end
    bus.num_re    = v.nr;
    bus.num_im    = v.ni;
    bus.num_valid = 1'b1;
    if (v.gap > 0) begin
      @(negedge clk);
      bus.num_valid = 1'b0;
      repeat (v.gap - 1) @(negedge clk);
      compareVal("num_ready_while_waiting", int'(bus.num_ready), 0);
    end
    bus.den_re    = v.dr;
    bus.den_im    = v.di;
    bus.den_valid = 1'b1;
    @(negedge clk);
    bus.num_valid = 1'b0;
    bus.den_valid = 1'b0;
    captureCycle  = cycle;
  endtask

  task automatic checkOutput(input string nm, input int expLat, input int hold);
    exp_t e;
    int   waited = 0;
    while (!bus.dout_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL %s_scoreboard: queue size 0, expected 1", nm);
      return;
    end
    e = sb.pop_front();
    if (!bus.dout_valid) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout: dout_valid 0 after %0d cycles, expected 1", nm, waited);
      return;
    end
    compareVal({nm, "_latency"}, cycle - captureCycle, expLat);
    compareVal({nm, "_re"}, int'(bus.dout_re), int'(e.er));
    compareVal({nm, "_im"}, int'(bus.dout_im), int'(e.ei));
    compareVal({nm, "_dbz"}, int'(bus.dout_div_by_zero), int'(e.edbz));
    compareVal({nm, "_busy_ready"}, int'(bus.num_ready) + int'(bus.den_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      compareVal({nm, "_hold_re"}, int'(bus.dout_re), int'(e.er));
      compareVal({nm, "_hold_im"}, int'(bus.dout_im), int'(e.ei));
      compareVal({nm, "_hold_valid"}, int'(bus.dout_valid), 1);
      compareVal({nm, "_hold_ready"}, int'(bus.num_ready) + int'(bus.den_ready), 0);
    end
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.dout_ready = 1'b0;
    compareVal({nm, "_valid_cleared"}, int'(bus.dout_valid), 0);
    compareVal({nm, "_num_ready_back"}, int'(bus.num_ready), 1);
    compareVal({nm, "_den_ready_back"}, int'(bus.den_ready), 1);
  endtask

  initial begin
    int rises;
    reset = 1'b1;
    enable = 1'b1;
    bus.num_re = '0; bus.num_im = '0; bus.num_valid = 1'b0;
    bus.den_re = '0; bus.den_im = '0; bus.den_valid = 1'b0;
    bus.dout_ready = 1'b0;

    vecs[0] = mk(16384, 16384, 0, 16384, 0, 10, 16384, -16384, 0);
    vecs[1] = mk(16384, -16384, 4096, 0, 0, 0, 32767, -32768, 0);
    vecs[2] = mk(3000, -4000, 1000, 2000, 0, 0, -16384, -32768, 0);
    vecs[3] = mk(-32768, 0, -32768, -32768, 0, 0, 8192, -8192, 0);
    vecs[4] = mk(7, 5, 200, -300, 0, 0, -12, 390, 0);
    vecs[5] = mk(32767, 0, 16384, 0, 0, 0, 32767, 0, 0);

    repeat (3) @(negedge clk);
    compareVal("rst_num_ready", int'(bus.num_ready), 1);
    compareVal("rst_den_ready", int'(bus.den_ready), 1);
    compareVal("rst_valid", int'(bus.dout_valid), 0);
    compareVal("rst_dbz", int'(bus.dout_div_by_zero), 0);
    compareVal("rst_re", int'(bus.dout_re), 0);
    compareVal("rst_im", int'(bus.dout_im), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput($sformatf("vec%0d", i), 51, vecs[i].hold);
    end

    applyStimulus(mk(-1, 0, 3, 0, 3, 0, -5461, 0, 0), 1'b1);
    checkOutput("order", 51, 0);

    applyStimulus(mk(100, 200, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    checkOutput("divzero", 5, 0);
    applyStimulus(mk(3000, -4000, 1000, 2000, 0, 0, -16384, -32768, 0), 1'b1);
    checkOutput("after_divzero", 51, 0);

    // Reset lands on the edge performing division iteration 20.
    applyStimulus(mk(16384, 0, 16384, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (23) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compareVal("abort_num_ready", int'(bus.num_ready), 1);
    compareVal("abort_den_ready", int'(bus.den_ready), 1);
    compareVal("abort_re", int'(bus.dout_re), 0);
    rises = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.dout_valid) rises++;
    end
    compareVal("abort_valid_rises", rises, 0);
    applyStimulus(mk(16384, 0, 16384, 0, 0, 0, 16384, 0, 0), 1'b1);
    checkOutput("after_abort", 51, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
